// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the reset release sequencer.
// Holds the sequencer state encoding and the lock-loss counter limits.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_DDR_WAIT,
    S_CORE_HOLD,
    S_APP_HOLD,
    S_RUN
  } state_t;

  localparam int LOCK_CNT_W = 8;

  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = 8'd255;

endpackage

// File: rtl/rst_seq.sv
// rst_seq: staged DDR -> core -> app reset release after PLL lock.
// Optional calibration timeout/retry: define RST_SEQ_CALIB_TIMEOUT_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYC   = 16,
  parameter int CORE_HOLD_CYC     = 64,
  parameter int APP_HOLD_CYC      = 32,
  parameter int CNT_W             = 16,
  parameter int CALIB_TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  calib_done,
  output logic                  rst_ddr_n,
  output logic                  rst_core_n,
  output logic                  rst_app_n,
  output logic                  seq_done,
  output logic [LOCK_CNT_W-1:0] lock_lost_cnt,
  output logic                  calib_timeout
);

  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LAST =
    CNT_W'(CORE_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] APP_LAST =
    CNT_W'(APP_HOLD_CYC - 1);

  if (LOCK_STABLE_CYC < 2 || CORE_HOLD_CYC < 2 ||
      APP_HOLD_CYC < 2 ||
      LOCK_STABLE_CYC >= (1 << CNT_W) ||
      CORE_HOLD_CYC >= (1 << CNT_W) ||
      APP_HOLD_CYC >= (1 << CNT_W) ||
      CALIB_TIMEOUT_CYC >= (1 << CNT_W)) begin : g_bad_cfg
    $error("rst_seq: cycle counts out of range");
  end

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(CALIB_TIMEOUT_CYC - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_loss;
  logic             calib_loss;

  // Lock matters once DDR is out of reset; calib once core hold began.
  assign lock_loss = !pll_locked &&
    (state inside {S_DDR_WAIT, S_CORE_HOLD,
                   S_APP_HOLD, S_RUN});
  assign calib_loss = !calib_done &&
    (state inside {S_CORE_HOLD, S_APP_HOLD, S_RUN});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_RESET;
      cnt           <= '0;
      rst_ddr_n     <= 1'b0;
      rst_core_n    <= 1'b0;
      rst_app_n     <= 1'b0;
      seq_done      <= 1'b0;
      lock_lost_cnt <= '0;
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
      calib_timeout <= 1'b0;
`endif
    end else if (lock_loss) begin
      state      <= S_WAIT_LOCK;
      cnt        <= '0;
      rst_ddr_n  <= 1'b0;
      rst_core_n <= 1'b0;
      rst_app_n  <= 1'b0;
      seq_done   <= 1'b0;
      if (lock_lost_cnt != LOCK_CNT_MAX)
        lock_lost_cnt <= lock_lost_cnt + LOCK_CNT_W'(1);
    end else if (calib_loss) begin
      state      <= S_DDR_WAIT;
      cnt        <= '0;
      rst_core_n <= 1'b0;
      rst_app_n  <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      unique case (state)
        S_RESET: begin
          state <= S_WAIT_LOCK;
          cnt   <= '0;
        end
        S_WAIT_LOCK: begin
          if (!pll_locked) begin
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            state     <= S_DDR_WAIT;
            rst_ddr_n <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DDR_WAIT: begin
          if (calib_done) begin
            state <= S_CORE_HOLD;
            cnt   <= '0;
          end
`ifdef RST_SEQ_CALIB_TIMEOUT_EN
          // Give up on this calibration and requalify lock first.
          else if (cnt == TO_LAST) begin
            state         <= S_WAIT_LOCK;
            rst_ddr_n     <= 1'b0;
            calib_timeout <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        S_CORE_HOLD: begin
          if (cnt == CORE_LAST) begin
            state      <= S_APP_HOLD;
            rst_core_n <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_APP_HOLD: begin
          if (cnt == APP_LAST) begin
            state     <= S_RUN;
            rst_app_n <= 1'b1;
            seq_done  <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          cnt <= '0;
        end
        default: begin
          state <= S_RESET;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef RST_SEQ_CALIB_TIMEOUT_EN
  assign calib_timeout = 1'b0;
`endif

endmodule
